// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier, one partial-product step per clock, driving an external adder.
// Optional build macro SEQ_MULTIPLIER_ZERO_SKIP_EN: zero operands finish in one cycle.
module seq_multiplier #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [DATA_WIDTH-1:0]   X,
    input  logic [DATA_WIDTH-1:0]   Y,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [2*DATA_WIDTH-1:0] P,
    output logic [DATA_WIDTH-1:0]   ADD_A,
    output logic [DATA_WIDTH-1:0]   ADD_B,
    output logic                    ADD_CI,
    input  logic [DATA_WIDTH-1:0]   ADD_S,
    input  logic                    ADD_CO
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [DATA_WIDTH-1:0]   r_mq;
    logic [DATA_WIDTH-1:0]   r_md;
    logic [CW-1:0]           r_cnt;
    logic [2*DATA_WIDTH-1:0] r_p;
    logic                    w_zero_op;

    assign w_zero_op = (X == '0) || (Y == '0);

    // Adder operands come only from registers, so no loop through the external adder.
    assign ADD_A  = r_acc;
    assign ADD_B  = r_mq[0] ? r_md : '0;
    assign ADD_CI = 1'b0;

    assign BUSY = (r_state != S_IDLE);
    assign DONE = (r_state == S_DONE);
    assign P    = r_p;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_mq    <= '0;
            r_md    <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_md    <= X;
                        r_mq    <= Y;
                        r_acc   <= '0;
                        r_cnt   <= CW'(DATA_WIDTH);
                        r_state <= S_RUN;
`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
                        if (w_zero_op) begin
                            r_p     <= '0;
                            r_state <= S_DONE;
                        end
`endif
                    end
                end
                S_RUN: begin
                    // Carry-out becomes the new ACC MSB; sum LSB shifts into MQ.
                    r_acc <= {ADD_CO, ADD_S[DATA_WIDTH-1:1]};
                    r_mq  <= {ADD_S[0], r_mq[DATA_WIDTH-1:1]};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_p     <= {ADD_CO, ADD_S, r_mq[DATA_WIDTH-1:1]};
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifndef SEQ_MULTIPLIER_ZERO_SKIP_EN
    logic w_unused;
    assign w_unused = w_zero_op;
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier (DATA_WIDTH=8) with a behavioural adder model.
module tb_seq_multiplier;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic           busy, done, add_ci, add_co;
    logic [2*W-1:0] p;
    logic [W-1:0]   add_a, add_b, add_s;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

`ifdef SEQ_MULTIPLIER_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    seq_multiplier #(.DATA_WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .START(start), .X(x), .Y(y),
        .BUSY(busy), .DONE(done), .P(p),
        .ADD_A(add_a), .ADD_B(add_b), .ADD_CI(add_ci),
        .ADD_S(add_s), .ADD_CO(add_co)
    );

    // Ripple-carry adder stand-in.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        return (SKIP && (a == 0 || b == 0)) ? 1 : W + 1;
    endfunction

    // One full multiply: start pulse, wait for DONE, check result, latency and return to IDLE.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp, input string tag,
                           output logic co_seen, output logic ci_seen);
        int c, bc;
        x = a; y = b; start = 1'b1;
        step();
        start = 1'b0;
        c = 1; bc = 0; co_seen = 1'b0; ci_seen = 1'b0;
        while (c <= 40) begin
            if (busy)   bc++;
            if (add_co) co_seen = 1'b1;
            if (add_ci) ci_seen = 1'b1;
            if (done) break;
            step();
            c++;
        end
        check({tag, " latency"}, c, exp_lat(a, b));
        check({tag, " P"}, {16'd0, p}, {16'd0, exp});
        check({tag, " busy cycles"}, bc, exp_lat(a, b));
        step();
        check({tag, " done drops"}, {31'd0, done}, 32'd0);
        check({tag, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic co_s, ci_s;
        int c, k, d0;
        logic [W-1:0] ra, rb;

        // Reset is asynchronous: outputs clear before any clock edge.
        #2 rst = 1'b1;
        #2;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst P", {16'd0, p}, 32'd0);
        check("rst add_a", {24'd0, add_a}, 32'd0);
        check("rst add_b", {24'd0, add_b}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();

        run_mul(8'd13, 8'd11, 16'h008F, "13x11", co_s, ci_s);

        run_mul(8'd255, 8'd255, 16'hFE01, "255x255", co_s, ci_s);
        check("255x255 co seen", {31'd0, co_s}, 32'd1);
        check("255x255 ci zero", {31'd0, ci_s}, 32'd0);

        run_mul(8'd0, 8'd200, 16'h0000, "0x200", co_s, ci_s);

        // START held high; operands change mid-run and must not leak into the result.
        x = 8'd3; y = 8'd5; start = 1'b1;
        step();
        c = 1;
        repeat (3) begin step(); c++; end
        x = 8'd7; y = 8'd9;
        while (!done && c < 40) begin step(); c++; end
        check("held first latency", c, W + 1);
        check("held first P", {16'd0, p}, 32'd15);
        k = 0;
        do begin step(); k++; end while (!done && k < 40);
        check("held gap edges", k, W + 2);
        check("held second P", {16'd0, p}, 32'd63);
        start = 1'b0;
        step();

        // Abort mid-run with an asynchronous reset.
        x = 8'd100; y = 8'd100; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort P", {16'd0, p}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("abort no done pulse", done_cnt, d0);
        run_mul(8'd100, 8'd100, 16'h2710, "100x100", co_s, ci_s);

        d0 = done_cnt;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_mul(ra, rb, 16'(ra) * 16'(rb), "rand", co_s, ci_s);
        end
        check("rand done count", done_cnt - d0, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
